rom_stream_arbiter: RTL

Round-robin arbiter that shares one valid/ready byte stream sink, for example a UART transmitter, between N sequential message sources. Each source is a hello_rom-style read port: `get`/`out`/`empty`, with data registered one cycle after `get`. The block grants one non-empty source, drains its whole message beat by beat into the sink, and pulses `done`. It then re-arbitrates starting after the last served source.

---
 rtl/rom_stream_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rom_stream_arbiter.sv
// Round-robin arbiter that drains one hello_rom-style source at a time into a
// single valid/ready byte sink, pulsing done after each whole message.
module rom_stream_arbiter #(
  parameter  int N  = 2,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  output logic [N-1:0]   src_get,
  input  logic [N*W-1:0] src_data,
  input  logic [N-1:0]   src_empty,
  output logic           m_valid,
  output logic [W-1:0]   m_data,
  input  logic           m_ready,
  output logic           busy,
  output logic [SW-1:0]  sel,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

  state_t         state, next_state;
  logic [SW-1:0]  last, next_last;
  logic [SW-1:0]  next_sel;
  logic           next_valid;
  logic [W-1:0]   next_data;
  logic           next_done;

  logic [N-1:0]   req;
  logic [W-1:0]   src_word [N];
  logic [SW-1:0]  winner;
  logic [SW-1:0]  cand;
  logic           found;

  assign req  = ~src_empty;
  assign busy = (state != IDLE);

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign src_word[g] = src_data[g*W +: W];
  end

  // Search starts just after the last served source and wraps around.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = SW'((int'(last) + 1 + i) % N);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      last    <= SW'(N - 1);
      m_valid <= 1'b0;
      m_data  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      sel     <= next_sel;
      last    <= next_last;
      m_valid <= next_valid;
      m_data  <= next_data;
      done    <= next_done;
    end
  end

  always_comb begin
    next_state = state;
    next_sel   = sel;
    next_last  = last;
    next_valid = m_valid;
    next_data  = m_data;
    next_done  = 1'b0;
    src_get    = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          next_sel   = winner;
          next_state = FETCH;
        end
      end
      FETCH: begin
        // A grant whose source is already empty closes as a zero-length message.
        if (src_empty[sel]) begin
          next_done  = 1'b1;
          next_last  = sel;
          next_state = IDLE;
        end else begin
          src_get[sel] = 1'b1;
          next_state   = LOAD;
        end
      end
      LOAD: begin
        next_data  = src_word[sel];
        next_valid = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        if (m_ready) begin
          next_valid = 1'b0;
          if (src_empty[sel]) begin
            next_done  = 1'b1;
            next_last  = sel;
            next_state = IDLE;
          end else begin
            src_get[sel] = 1'b1;
            next_state   = LOAD;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    if (reset) src_get = '0;
  end

endmodule
